// File: rtl/led_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver running on sysclk.
// ledclk is sampled as data; new values are swapped in only at the frame wrap.
module led_scan_driver #(
  parameter logic BLANK_LEADING  = 1'b1,
  parameter logic AN_ACTIVE_LOW  = 1'b1,
  parameter logic SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        ledclk,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  logic        r_s1, r_s2, r_s3;
  logic [1:0]  r_idx;
  logic [15:0] r_dispVal, r_holdVal;
  logic [3:0]  r_dispDp, r_holdDp;
  logic        r_pending, r_frameDone;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_tick, w_wrap;
  logic [1:0]  w_idxNext;
  logic [15:0] w_dispValNext, w_holdValNext;
  logic [3:0]  w_dispDpNext, w_holdDpNext;
  logic        w_pendingNext;
  logic [3:0]  w_nibble;
  logic        w_blank;
  logic [6:0]  w_segOn;
  logic [3:0]  w_anOn;
  logic        w_dpOn;

  assign w_tick    = r_s2 & ~r_s3;
  assign w_wrap    = w_tick & (r_idx == 2'd3);
  assign w_idxNext = w_tick ? r_idx + 2'd1 : r_idx;

  // A load coinciding with the wrap bypasses the holding registers entirely.
  always_comb begin
    w_dispValNext = r_dispVal;
    w_dispDpNext  = r_dispDp;
    w_holdValNext = r_holdVal;
    w_holdDpNext  = r_holdDp;
    w_pendingNext = r_pending;
    if (w_wrap && load) begin
      w_dispValNext = value_in;
      w_dispDpNext  = dp_in;
      w_pendingNext = 1'b0;
    end else if (w_wrap && r_pending) begin
      w_dispValNext = r_holdVal;
      w_dispDpNext  = r_holdDp;
      w_pendingNext = 1'b0;
    end else if (load) begin
      w_holdValNext = value_in;
      w_holdDpNext  = dp_in;
      w_pendingNext = 1'b1;
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    w_blank  = 1'b0;
    case (w_idxNext)
      2'd0: w_nibble = w_dispValNext[3:0];
      2'd1: begin
        w_nibble = w_dispValNext[7:4];
        w_blank  = BLANK_LEADING && (w_dispValNext[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble = w_dispValNext[11:8];
        w_blank  = BLANK_LEADING && (w_dispValNext[15:8] == 8'h00);
      end
      default: begin
        w_nibble = w_dispValNext[15:12];
        w_blank  = BLANK_LEADING && (w_dispValNext[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    w_segOn = 7'h00;
    case (w_nibble)
      4'h0: w_segOn = 7'h3F;
      4'h1: w_segOn = 7'h06;
      4'h2: w_segOn = 7'h5B;
      4'h3: w_segOn = 7'h4F;
      4'h4: w_segOn = 7'h66;
      4'h5: w_segOn = 7'h6D;
      4'h6: w_segOn = 7'h7D;
      4'h7: w_segOn = 7'h07;
      4'h8: w_segOn = 7'h7F;
      4'h9: w_segOn = 7'h6F;
      4'hA: w_segOn = 7'h77;
      4'hB: w_segOn = 7'h7C;
      4'hC: w_segOn = 7'h39;
      4'hD: w_segOn = 7'h5E;
      4'hE: w_segOn = 7'h79;
      default: w_segOn = 7'h71;
    endcase
    if (w_blank) w_segOn = 7'h00;
  end

  assign w_anOn = w_blank ? 4'b0000 : (4'b0001 << w_idxNext);
  assign w_dpOn = ~w_blank & w_dispDpNext[w_idxNext];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_idx       <= 2'd0;
      r_dispVal   <= 16'h0000;
      r_dispDp    <= 4'h0;
      r_holdVal   <= 16'h0000;
      r_holdDp    <= 4'h0;
      r_pending   <= 1'b0;
      r_frameDone <= 1'b0;
      r_an        <= {4{AN_ACTIVE_LOW}};
      r_seg       <= {7{SEG_ACTIVE_LOW}};
      r_dp        <= SEG_ACTIVE_LOW;
    end else begin
      r_s1        <= ledclk;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_idx       <= w_idxNext;
      r_dispVal   <= w_dispValNext;
      r_dispDp    <= w_dispDpNext;
      r_holdVal   <= w_holdValNext;
      r_holdDp    <= w_holdDpNext;
      r_pending   <= w_pendingNext;
      r_frameDone <= w_wrap;
      // Display outputs only move on a scan tick, so they stay dark until the first one.
      if (w_tick) begin
        r_an  <= AN_ACTIVE_LOW  ? ~w_anOn  : w_anOn;
        r_seg <= SEG_ACTIVE_LOW ? ~w_segOn : w_segOn;
        r_dp  <= SEG_ACTIVE_LOW ? ~w_dpOn  : w_dpOn;
      end
    end
  end

  assign pending    = r_pending;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frameDone;

endmodule
